// File: rtl/data_mem_ws.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ws
//  Purpose  : Word-addressed data RAM with a request/acknowledge handshake,
//             a configurable number of wait states, byte-enabled writes and
//             out-of-range error reporting.
//  Ports    : CLK, RST        - clock, synchronous active-high reset
//             REQ, WE, BE     - request, write enable, byte enables
//             ADDRESS         - word address
//             WRITE_DATA      - write data
//             READ_DATA       - registered read data, valid with ACK
//             ACK, ERR        - one-cycle completion / error pulses
//             BUSY            - access in flight (wait states)
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ws #(
    parameter int N           = 1024,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ,
    input  logic                   WE,
    input  logic [DATA_W/8-1:0]    BE,
    input  logic [$clog2(N)-1:0]   ADDRESS,
    input  logic [DATA_W-1:0]      WRITE_DATA,
    output logic [DATA_W-1:0]      READ_DATA,
    output logic                   ACK,
    output logic                   BUSY,
    output logic                   ERR
);

    localparam int c_ADDR_W = $clog2(N);
    localparam int c_NB     = DATA_W / 8;

    // One extra bit so that N itself is representable when N is a power of two.
    localparam logic [c_ADDR_W:0] c_N = (c_ADDR_W + 1)'(N);

    localparam logic [3:0] c_WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    logic                r_we;
    logic [c_NB-1:0]     r_be;
    logic [c_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic [DATA_W-1:0]   r_mem [N];

    logic                w_accept;
    logic                w_exec;
    logic                w_ex_we;
    logic [c_NB-1:0]     w_ex_be;
    logic [c_ADDR_W-1:0] w_ex_addr;
    logic [DATA_W-1:0]   w_ex_wdata;
    logic                w_in_range;

    // A request is taken whenever no wait states are pending; the RESP
    // (ACK) cycle counts as free so back-to-back accesses need no gap.
    assign w_accept = REQ && (r_state != c_S_WAIT);

    // With no wait states the access executes at the very edge it is
    // accepted, so the live inputs are used instead of the latched copy.
    assign w_ex_we    = (WAIT_STATES == 0) ? WE         : r_we;
    assign w_ex_be    = (WAIT_STATES == 0) ? BE         : r_be;
    assign w_ex_addr  = (WAIT_STATES == 0) ? ADDRESS    : r_addr;
    assign w_ex_wdata = (WAIT_STATES == 0) ? WRITE_DATA : r_wdata;

    // The access commits on the edge that enters RESP; reset at that same
    // edge aborts it.
    assign w_exec = !RST && ((WAIT_STATES == 0) ? w_accept
                                                : (r_state == c_S_WAIT && r_cnt == 4'd0));

    assign w_in_range = ({1'b0, w_ex_addr} < c_N);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE, c_S_RESP: begin
                if (REQ) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = c_S_RESP;
                    end else begin
                        w_state_nxt = c_S_WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request fields are held untouched while wait states are pending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= WE;
            r_be    <= BE;
            r_addr  <= ADDRESS;
            r_wdata <= WRITE_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_exec && !w_in_range;
            // Only reads touch READ_DATA; writes leave the last read visible.
            if (w_exec && !w_ex_we) begin
                r_rdata <= w_in_range ? r_mem[w_ex_addr] : '0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (w_exec && w_ex_we && w_in_range) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_ex_be[i]) begin
                    r_mem[w_ex_addr][8*i +: 8] <= w_ex_wdata[8*i +: 8];
                end
            end
        end
    end

    assign READ_DATA = r_rdata;
    assign ACK       = (r_state == c_S_RESP);
    assign BUSY      = (r_state == c_S_WAIT);
    assign ERR       = r_err;

endmodule
`default_nettype wire
